// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction fetch queue between the fetch stage and a
// tagged, possibly out-of-order memory. Each slot tracks one outstanding fetch
// from request acceptance until the processor consumes it (or a redirect kills it).
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] proc2mem_addr,
  output logic [3:0]  proc2mem_command,
  input  logic [3:0]  mem2proc_response,
  input  logic [31:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fb_valid,
  output logic [31:0] fb_inst,
  output logic [31:0] fb_pc,
  input  logic        fb_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Memory command codes shared with the memory model (sys_defs.vh values)
  localparam logic [3:0] MEM_NONE = 4'h0;
  localparam logic [3:0] MEM_LW   = 4'h1;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_READY   = 2'd2
  } slot_state_e;

  slot_state_e        st_q   [DEPTH];
  logic               kill_q [DEPTH];
  logic [3:0]         tag_q  [DEPTH];
  logic [31:0]        pc_q   [DEPTH];
  logic [31:0]        data_q [DEPTH];

  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        fetch_pc_q;
  // Low until the first edge with reset released, so no request is driven
  // while the buffer is coming out of reset.
  logic               started_q;

  logic               issue_c;
  logic               accept_c;
  logic               head_ready_c;
  logic               pop_c;
  logic               autofree_c;
  logic               free_c;
  logic               match_hit_c;
  logic [PTR_W-1:0]   match_idx_c;

  // Issue/accept/pop/free decisions for this cycle
  always_comb begin
    issue_c      = rst && started_q && (count_q < CNT_W'(DEPTH)) && !redirect_valid;
    accept_c     = issue_c && (mem2proc_response != 4'h0);
    head_ready_c = (st_q[head_q] == SLOT_READY);
    fb_valid     = rst && head_ready_c && !kill_q[head_q] && !redirect_valid;
    pop_c        = fb_valid && fb_ready;
    autofree_c   = rst && head_ready_c && kill_q[head_q];
    free_c       = pop_c || autofree_c;
  end

  // Locate the pending slot a returning tag belongs to
  always_comb begin
    match_hit_c = 1'b0;
    match_idx_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!match_hit_c && (mem2proc_tag != 4'h0) &&
          (st_q[i] == SLOT_PENDING) && (tag_q[i] == mem2proc_tag)) begin
        match_hit_c = 1'b1;
        match_idx_c = PTR_W'(i);
      end
    end
  end

  // Slot array, pointers, occupancy and fetch address
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i]   <= SLOT_EMPTY;
        kill_q[i] <= 1'b0;
        tag_q[i]  <= 4'h0;
        pc_q[i]   <= 32'h0;
        data_q[i] <= 32'h0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      started_q  <= 1'b0;
    end else begin
      started_q <= 1'b1;

      if (redirect_valid) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (st_q[i] != SLOT_EMPTY) kill_q[i] <= 1'b1;
        end
      end

      if (match_hit_c) begin
        st_q[match_idx_c]   <= SLOT_READY;
        data_q[match_idx_c] <= mem2proc_data;
      end

      // Freed head is READY and the allocated tail is EMPTY, so neither can
      // collide with the returning slot or with each other.
      if (free_c) begin
        st_q[head_q]   <= SLOT_EMPTY;
        kill_q[head_q] <= 1'b0;
        head_q         <= head_q + PTR_W'(1);
      end

      if (accept_c) begin
        st_q[tail_q]   <= SLOT_PENDING;
        kill_q[tail_q] <= 1'b0;
        tag_q[tail_q]  <= mem2proc_response;
        pc_q[tail_q]   <= fetch_pc_q;
        tail_q         <= tail_q + PTR_W'(1);
        fetch_pc_q     <= fetch_pc_q + 32'd4;
      end else if (redirect_valid) begin
        fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
      end

      case ({accept_c, free_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Request and head-of-queue outputs
  always_comb begin
    proc2mem_addr    = fetch_pc_q;
    proc2mem_command = issue_c ? MEM_LW : MEM_NONE;
    fb_inst          = data_q[head_q];
    fb_pc            = pc_q[head_q];
  end

endmodule
